hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/sat_counter16.sv | 20 ++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t     : FSM state encoding (RUN=0, REDIRECT=1, MEMWAIT=2; 3 unused)
//   PC_*        : EXPCSrc next-PC source codes
//   load_use_hit: load in EX writes a register the ID instruction reads
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_MEMWAIT  = 2'd2
   } state_t;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_J   = 2'b10;
   localparam logic [1:0] PC_JR  = 2'b11;

   // Register 0 is hardwired, so a load targeting it never creates a hazard.
   function automatic logic load_use_hit(input logic       mem_read,
                                         input logic [4:0] ex_rt,
                                         input logic [4:0] id_rs,
                                         input logic [4:0] id_rt,
                                         input logic       uses_rt);
      return mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
//   Inputs to the controller : IDEXMemRead, IDEXRt, IFIDRs, IFIDRt,
//                              IFIDUsesRt, EXPCSrc, MemBusy
//   Outputs of the controller: PCWrite, IFIDWrite, IFIDFlush, IDEXWrite,
//                              IDEXFlush, StallCount, FlushCount, State
//   master : pipeline / stimulus side   slave : hazard_ctrl side
interface hazard_ctrl_if;
   logic        IDEXMemRead;
   logic [4:0]  IDEXRt;
   logic [4:0]  IFIDRs;
   logic [4:0]  IFIDRt;
   logic        IFIDUsesRt;
   logic [1:0]  EXPCSrc;
   logic        MemBusy;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        IFIDFlush;
   logic        IDEXWrite;
   logic        IDEXFlush;
   logic [15:0] StallCount;
   logic [15:0] FlushCount;
   logic [1:0]  State;

   modport master (
      output IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, IFIDUsesRt, EXPCSrc, MemBusy,
      input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
             StallCount, FlushCount, State
   );

   modport slave (
      input  IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, IFIDUsesRt, EXPCSrc, MemBusy,
      output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush,
             StallCount, FlushCount, State
   );
endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high clear
//   inc   : count this cycle
//   count : registered count value
module sat_counter16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= 16'd0;
      else if (inc && (count != 16'hFFFF))
         count <= count + 16'd1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump redirects and
// data-memory wait states, plus stall/flush statistics counters.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : hazard_ctrl_if.slave (pipeline status in, enables/flushes out)
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RUN      | normal issue; detect load-use and redirects
// ST_REDIRECT | fetch latency cycle after a redirect; IF/ID still flushed
// ST_MEMWAIT  | pipeline frozen while data memory is busy
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
);

   state_t state, state_nxt;
   logic   pend, pend_nxt;
   logic   redir, lu, redirect_phase;
   logic   stall_inc, flush_inc;

   assign redir = (bus.EXPCSrc != PC_SEQ);
   assign lu    = load_use_hit(bus.IDEXMemRead, bus.IDEXRt, bus.IFIDRs,
                               bus.IFIDRt, bus.IFIDUsesRt);

   // A redirect that arrived while memory was busy is replayed as the
   // fetch-latency cycle once the memory frees up.
   assign redirect_phase = (state == ST_REDIRECT) ||
                           ((state == ST_MEMWAIT) && pend);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         pend  <= 1'b0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
      end
   end

   always_comb begin
      bus.PCWrite   = 1'b1;
      bus.IFIDWrite = 1'b1;
      bus.IFIDFlush = 1'b0;
      bus.IDEXWrite = 1'b1;
      bus.IDEXFlush = 1'b0;
      state_nxt     = ST_RUN;
      pend_nxt      = pend;
      stall_inc     = 1'b0;

      if (bus.MemBusy) begin
         bus.PCWrite   = 1'b0;
         bus.IFIDWrite = 1'b0;
         bus.IDEXWrite = 1'b0;
         state_nxt     = ST_MEMWAIT;
         stall_inc     = 1'b1;
         if ((state == ST_REDIRECT) || ((state != ST_MEMWAIT) && redir))
            pend_nxt = 1'b1;
      end else begin
         if (state == ST_MEMWAIT)
            pend_nxt = 1'b0;
         if (redir) begin
            bus.IFIDFlush = 1'b1;
            bus.IDEXFlush = 1'b1;
            state_nxt     = ST_REDIRECT;
         end else if (redirect_phase) begin
            bus.IFIDFlush = 1'b1;
         end else if (lu) begin
            // The bubble clears IDEXMemRead next cycle, so one hit stalls once.
            bus.PCWrite   = 1'b0;
            bus.IFIDWrite = 1'b0;
            bus.IDEXFlush = 1'b1;
            stall_inc     = 1'b1;
         end
      end

      if (rst) begin
         bus.PCWrite   = 1'b0;
         bus.IFIDWrite = 1'b0;
         bus.IDEXWrite = 1'b0;
         bus.IFIDFlush = 1'b1;
         bus.IDEXFlush = 1'b1;
      end
   end

   assign flush_inc = bus.IFIDFlush;
   assign bus.State = state;

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (bus.StallCount)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (bus.FlushCount)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios, random
// traffic against a rule-level reference model, counter saturation and
// asynchronous reset.
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   hazard_ctrl_if bus ();

   hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: pipeline phase (0 issue, 1 fetch-latency after a
   // redirect, 2 frozen on memory), deferred-redirect flag, event totals.
   int m_mode  = 0;
   bit m_pend  = 1'b0;
   int m_stall = 0;
   int m_flush = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [4:0] dut_outs();
      return {bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXWrite,
              bus.IDEXFlush};
   endfunction

   // One clock cycle: apply inputs just after the edge, check mid-cycle,
   // then advance the model across the next rising edge.
   task automatic cyc(input logic mr, input logic [4:0] xrt,
                      input logic [4:0] rs, input logic [4:0] irt,
                      input logic ur, input logic [1:0] pc,
                      input logic mb, input bit do_chk);
      logic [4:0] eo;
      int         nmode;
      bit         npend;
      bit         hit, redir, replay, sev;
      bus.IDEXMemRead = mr;
      bus.IDEXRt      = xrt;
      bus.IFIDRs      = rs;
      bus.IFIDRt      = irt;
      bus.IFIDUsesRt  = ur;
      bus.EXPCSrc     = pc;
      bus.MemBusy     = mb;
      #4;
      hit   = mr && (xrt != 0) && ((xrt == rs) || (ur && (xrt == irt)));
      redir = (pc != 2'b00);
      npend = m_pend;
      sev   = 1'b0;
      if (mb) begin
         eo    = 5'b00000;
         nmode = 2;
         sev   = 1'b1;
         if (m_mode == 1 || (m_mode == 0 && redir)) npend = 1'b1;
      end else begin
         replay = (m_mode == 1) || (m_mode == 2 && m_pend);
         if (m_mode == 2) npend = 1'b0;
         nmode = 0;
         if (redir) begin
            eo    = 5'b11111;
            nmode = 1;
         end else if (replay) begin
            eo = 5'b11110;
         end else if (hit) begin
            eo  = 5'b00011;
            sev = 1'b1;
         end else begin
            eo = 5'b11010;
         end
      end
      if (do_chk) begin
         chk("outputs", 32'(dut_outs()), 32'(eo));
         chk("State", 32'(bus.State), 32'(m_mode));
         chk("StallCount", 32'(bus.StallCount), 32'(m_stall));
         chk("FlushCount", 32'(bus.FlushCount), 32'(m_flush));
      end
      @(posedge clk);
      #1;
      m_mode = nmode;
      m_pend = npend;
      if (sev && m_stall < 65535) m_stall++;
      if (eo[2] && m_flush < 65535) m_flush++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 2'b00, 0, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_outputs", 32'(dut_outs()), 32'(5'b00101));
      chk("rst_State", 32'(bus.State), 32'd0);
      chk("rst_StallCount", 32'(bus.StallCount), 32'd0);
      chk("rst_FlushCount", 32'(bus.FlushCount), 32'd0);
      m_mode  = 0;
      m_pend  = 1'b0;
      m_stall = 0;
      m_flush = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.IDEXMemRead = 1'b0;
      bus.IDEXRt      = 5'd0;
      bus.IFIDRs      = 5'd0;
      bus.IFIDRt      = 5'd0;
      bus.IFIDUsesRt  = 1'b0;
      bus.EXPCSrc     = 2'b00;
      bus.MemBusy     = 1'b0;
      #2;
      chk("init_outputs", 32'(dut_outs()), 32'(5'b00101));
      chk("init_State", 32'(bus.State), 32'd0);
      chk("init_StallCount", 32'(bus.StallCount), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // load-use on Rs
      cyc(1, 8, 8, 0, 0, 2'b00, 0, 1);
      idle(1);
      chk("lu_stall_total", 32'(bus.StallCount), 32'd1);
      // Rt = 0, and Rt match without IFIDUsesRt: no stall
      cyc(1, 0, 0, 0, 0, 2'b00, 0, 1);
      cyc(1, 9, 1, 9, 0, 2'b00, 0, 1);
      // Rt match with IFIDUsesRt
      cyc(1, 9, 1, 9, 1, 2'b00, 0, 1);
      idle(1);
      // taken branch
      cyc(0, 0, 0, 0, 0, 2'b01, 0, 1);
      idle(2);
      chk("br_flush_total", 32'(bus.FlushCount), 32'd2);
      // jump while memory busy for three cycles
      cyc(0, 0, 0, 0, 0, 2'b10, 1, 1);
      cyc(0, 0, 0, 0, 0, 2'b10, 1, 1);
      cyc(0, 0, 0, 0, 0, 2'b10, 1, 1);
      idle(2);
      // load-use and jump-register together: redirect wins
      cyc(1, 8, 8, 0, 0, 2'b11, 0, 1);
      idle(2);
      // back-to-back redirects
      cyc(0, 0, 0, 0, 0, 2'b01, 0, 1);
      cyc(0, 0, 0, 0, 0, 2'b10, 0, 1);
      idle(2);
      // reset while frozen with a deferred redirect, then load-use from RUN
      cyc(0, 0, 0, 0, 0, 2'b01, 1, 1);
      cyc(0, 0, 0, 0, 0, 2'b00, 1, 1);
      do_reset();
      cyc(1, 5, 5, 0, 0, 2'b00, 0, 1);
      idle(2);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             1'($urandom_range(0, 5) == 0), 1);
      end

      // saturation: start from zero, then 65536 busy cycles
      do_reset();
      for (int i = 0; i < 65536; i++) cyc(0, 0, 0, 0, 0, 2'b00, 1, 0);
      chk("sat_StallCount", 32'(bus.StallCount), 32'hFFFF);
      cyc(0, 0, 0, 0, 0, 2'b00, 1, 1);
      chk("sat_hold", 32'(bus.StallCount), 32'hFFFF);
      // asynchronous reset in MEMWAIT
      bus.MemBusy = 1'b1;
      do_reset();
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
